// File: rtl/cpu_ctrl.sv
// Multi-cycle control FSM sequencing fetch, decode, register read, ALU execute and write-back.
// Define CPU_CTRL_BRANCH_EN to enable the JMP (1000) and BZ (1001) opcodes; otherwise they decode as illegal.
module cpu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        rf_rd_en,
    input  logic        rf_rd_valid,
    output logic [1:0]  rf_rd,
    output logic [1:0]  rf_rs,
    output logic [3:0]  rf_we,
    output logic        alu_start,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_imm,
    input  logic        alu_done,
    input  logic        alu_zero,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_READ, S_EXEC, S_WB, S_HALTED
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
        OP_OR   = 4'h4, OP_MOV = 4'h5, OP_LDI = 4'h6, OP_HALT = 4'h7,
        OP_JMP  = 4'h8, OP_BZ  = 4'h9
    } op_t;

    localparam logic [2:0] ALU_LDI = 3'b101;

    state_t      state;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        zero_flag;

    // Register ops ADD..MOV (1..5) map onto ALU codes 0..4.
    function automatic logic [2:0] alu_code(input logic [3:0] op);
        return 3'(op - 4'd1);
    endfunction

    assign imem_addr = pc;
    assign rf_rd     = ir[11:10];
    assign rf_rs     = ir[9:8];
    assign alu_imm   = ir[7:0];

`ifndef CPU_CTRL_BRANCH_EN
    logic unused_zero_flag;
    assign unused_zero_flag = zero_flag;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pc        <= 8'h00;
            ir        <= 16'h0000;
            zero_flag <= 1'b0;
            retired   <= 16'h0000;
            imem_req  <= 1'b0;
            rf_rd_en  <= 1'b0;
            rf_we     <= 4'b0000;
            alu_start <= 1'b0;
            alu_op    <= 3'b000;
            busy      <= 1'b0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle with non-blocking assigns; a later
            // assignment in the same block overrides it, so each pulse lasts exactly one cycle.
            illegal   <= 1'b0;
            alu_start <= 1'b0;
            rf_we     <= 4'b0000;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_data;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    case (ir[15:12])
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV: begin
                            rf_rd_en <= 1'b1;
                            state    <= S_READ;
                        end
                        OP_LDI: begin
                            alu_start <= 1'b1;
                            alu_op    <= ALU_LDI;
                            state     <= S_EXEC;
                        end
                        OP_HALT: begin
                            retired <= retired + 16'd1;
                            busy    <= 1'b0;
                            halted  <= 1'b1;
                            state   <= S_HALTED;
                        end
                        OP_NOP: begin
                            pc       <= pc + 8'd1;
                            retired  <= retired + 16'd1;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
`ifdef CPU_CTRL_BRANCH_EN
                        OP_JMP, OP_BZ: begin
                            if (ir[15:12] == OP_JMP || zero_flag)
                                pc <= ir[7:0];
                            else
                                pc <= pc + 8'd1;
                            retired  <= retired + 16'd1;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
`endif
                        default: begin
                            // Undefined opcodes flag and then retire as a NOP.
                            illegal  <= 1'b1;
                            pc       <= pc + 8'd1;
                            retired  <= retired + 16'd1;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    endcase
                end

                S_READ: begin
                    if (rf_rd_valid) begin
                        rf_rd_en  <= 1'b0;
                        alu_start <= 1'b1;
                        alu_op    <= alu_code(ir[15:12]);
                        state     <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (alu_done) begin
                        zero_flag <= alu_zero;
                        alu_op    <= 3'b000;
                        rf_we     <= 4'b0001 << ir[11:10];
                        state     <= S_WB;
                    end
                end

                S_WB: begin
                    pc       <= pc + 8'd1;
                    retired  <= retired + 16'd1;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end

                S_HALTED: begin
                    halted <= 1'b1;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins execution from IDLE
- imem_req  out  1  instruction fetch request
- imem_addr  out  8  program counter (pc)
- imem_ack  in  1  instruction valid; sampled while imem_req=1
- imem_data  in  16  instruction: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
- rf_rd_en  out  1  read enable to register file (drives its en_in)
- rf_rd_valid  in  1  register file read data valid (its en_out)
- rf_rd  out  2  destination/first-operand register index
- rf_rs  out  2  source register index
- rf_we  out  4  one-hot write enable (bit n writes rn); 0000 = no write
- alu_start  out  1  one-cycle ALU start pulse
- alu_op  out  3  ALU operation
- alu_imm  out  8  immediate to ALU
- alu_done  in  1  ALU result valid
- alu_zero  in  1  ALU result==0; sampled with alu_done
- busy  out  1  high in every state except IDLE and HALTED
- halted  out  1  high in HALTED
- illegal  out  1  one-cycle pulse on undefined opcode
- retired  out  16  retired-instruction count

Function
REQ-002 SHALL implement states IDLE, FETCH, DECODE, READ, EXEC, WB, HALTED.
REQ-003 IDLE: pc=0, all request outputs low; start=1 -> FETCH.
REQ-004 FETCH: imem_req=1, imem_addr=pc; hold until imem_ack=1, then latch imem_data into ir -> DECODE; no timeout.
REQ-005 DECODE (1 cycle) by ir[15:12]: 0000 NOP; 0001 ADD; 0010 SUB; 0011 AND; 0100 OR; 0101 MOV; 0110 LDI; 0111 HALT; 1000 JMP and 1001 BZ per REQ-016; others undefined.
REQ-006 NOP: pc+1, retired+1 -> FETCH. HALT: retired+1 -> HALTED, pc not advanced. Undefined: illegal pulses 1 cycle, treated as NOP.
REQ-007 ADD/SUB/AND/OR/MOV -> READ: rf_rd_en=1 with rf_rd=ir[11:10], rf_rs=ir[9:8], held until rf_rd_valid=1 (min 1 wait) -> EXEC; rf_rd_en low from EXEC on.
REQ-008 LDI skips READ: DECODE -> EXEC, alu_imm=ir[7:0].
REQ-009 EXEC: alu_start high in first EXEC cycle only; alu_op ADD=000, SUB=001, AND=010, OR=011, MOV(pass rs)=100, LDI(pass zero-extended imm)=101, held through EXEC; wait alu_done -> WB; zero flag <= alu_zero on alu_done.
REQ-010 WB (1 cycle): rf_we=1<<rd for exactly this cycle; pc+1; retired+1 -> FETCH.
REQ-011 pc 8 bits, wraps 0xFF -> 0x00; retired 16 bits, wraps 0xFFFF -> 0x0000.
REQ-012 HALTED: outputs idle, halted=1; only reset exits; start ignored.
REQ-013 start outside IDLE SHALL be ignored; alu_done/rf_rd_valid/imem_ack outside their waiting state SHALL be ignored.
REQ-014 rf_we SHALL never have more than one bit set and SHALL be 0000 outside WB.

Reset
REQ-015 rst=0 SHALL, asynchronously and at any state (including mid-handshake), force IDLE, pc=0, ir=0, zero flag=0, retired=0, and all outputs 0; in-flight ALU/fetch results are discarded.

Configuration
REQ-016 Macro CPU_CTRL_BRANCH_EN: defined -> JMP sets pc=imm; BZ sets pc=imm if zero flag=1 else pc+1; both DECODE -> FETCH, retired+1, no register write. Undefined -> 1000/1001 are undefined opcodes (illegal pulse, NOP behaviour).

Verification
REQ-017 Reset then start; ROM[0]=LDI r2,0x5A; ROM[1]=HALT -> EXEC alu_op=101, alu_imm=0x5A; WB rf_we=0100 one cycle; halted=1, retired=2, imem_addr=1.
REQ-018 ADD r1,r3 with rf_rd_valid delayed 3 cycles, alu_done delayed 2 -> rf_rd_en held 4 cycles, single alu_start pulse, rf_we=0010, pc+1.
REQ-019 Opcode 0xF at pc=0x10 -> illegal pulse one cycle, no rf_we, next fetch at 0x11; start pulses during run ignored.
REQ-020 256 NOPs from pc=0xFF region -> imem_addr wraps 0xFF -> 0x00; retired counts 256.
REQ-021 rst asserted while waiting alu_done -> IDLE immediately, all outputs 0; later alu_done causes no write.
REQ-022 With CPU_CTRL_BRANCH_EN: SUB r0,r0 (alu_zero=1) then BZ 0x40 -> next fetch 0x40; without macro -> illegal pulse, next fetch pc+1.
